// File: rtl/pea_out_collector.sv
`default_nettype none
// pea_out_collector: samples PE results with optional 1-of-(skip+1) decimation into a small FIFO,
// drains it over valid/ready, counts results per job and flags done / sticky overflow.
module pea_out_collector #(
  parameter int N_BITS     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [CNT_W-1:0]              cfg_len_i,
  input  logic [7:0]                    cfg_skip_i,
  input  logic [N_BITS-1:0]             pe_res_i,
  input  logic                          stream_valid_i,
  output logic [N_BITS-1:0]             out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  len_q, in_cnt, out_cnt;
  logic [7:0]        skip_q, dec_cnt;
  logic [N_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              overflow, done;

  logic full, pop, keep, push, drop, last_in, job_end;

  always_comb begin
    full    = (count == FULL_CNT);
    pop     = (state != IDLE) && (count != '0) && out_ready_i;
    keep    = (state == RUN) && stream_valid_i && (dec_cnt == skip_q);
    // a full FIFO still accepts a push when the head leaves on the same edge
    push    = keep && (!full || pop);
    drop    = keep && full && !pop;
    last_in = keep && ((in_cnt + CNT_W'(1)) == len_q);
    // once words were dropped out_cnt can never reach len, so wait for empty instead
    job_end = (state == DRAIN) &&
              (overflow ? (count == '0) : (pop && ((out_cnt + CNT_W'(1)) == len_q)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && (cfg_len_i != '0)) state_nxt = RUN;
      RUN:     if (last_in) state_nxt = DRAIN;
      DRAIN:   if (job_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      len_q    <= '0;
      skip_q   <= '0;
      dec_cnt  <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start_i) begin
        len_q    <= cfg_len_i;
        skip_q   <= cfg_skip_i;
        dec_cnt  <= '0;
        in_cnt   <= '0;
        out_cnt  <= '0;
        overflow <= 1'b0;
        if (cfg_len_i == '0) done <= 1'b1;
      end
      if ((state == RUN) && stream_valid_i)
        dec_cnt <= keep ? 8'd0 : dec_cnt + 8'd1;
      if (keep) in_cnt <= in_cnt + CNT_W'(1);
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        out_cnt <= out_cnt + CNT_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (job_end) done <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= pe_res_i;
  end

  // storage is not reset, so the head is masked while empty
  assign out_valid_o = (count != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
  assign busy_o      = (state != IDLE);
  assign done_o      = done;
  assign overflow_o  = overflow;
  assign fill_o      = count;

endmodule
`default_nettype wire

// File: tb/tb_pea_out_collector.sv
`default_nettype none
// tb_pea_out_collector: directed and randomized checks against a queue-based reference model.
module tb_pea_out_collector;
  localparam int N_BITS = 32, FIFO_DEPTH = 4, CNT_W = 16;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int VW = N_BITS + FW + 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stream_valid = 1'b0, out_ready = 1'b0;
  logic [CNT_W-1:0]  cfg_len = '0;
  logic [7:0]        cfg_skip = '0;
  logic [N_BITS-1:0] pe_res = '0;
  logic [N_BITS-1:0] out_data;
  logic              out_valid, busy, done, overflow;
  logic [FW-1:0]     fill;

  pea_out_collector #(.N_BITS(N_BITS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cfg_len_i(cfg_len), .cfg_skip_i(cfg_skip),
    .pe_res_i(pe_res), .stream_valid_i(stream_valid), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy), .done_o(done),
    .overflow_o(overflow), .fill_o(fill)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model: job bookkeeping plus a bounded queue
  logic [N_BITS-1:0] mq[$];
  bit m_busy = 0, m_drain = 0, m_done = 0, m_ovf = 0;
  int m_len = 0, m_skip = 0, m_dec = 0, m_in = 0, m_out = 0;

  logic [N_BITS-1:0] got[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && busy && out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
  end

  logic [VW-1:0] dut_vec;
  assign dut_vec = {out_valid, out_data, fill, busy, done, overflow};

  function automatic logic [VW-1:0] exp_vec();
    logic [N_BITS-1:0] d;
    d = (mq.size() != 0) ? mq[0] : '0;
    return {mq.size() != 0, d, FW'(mq.size()), m_busy, m_done, m_ovf};
  endfunction

  task automatic tick();
    int sz;
    bit pop, keep, fin, nd;
    sz = mq.size();
    nd = 0;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_drain = 0; m_ovf = 0; m_dec = 0; m_in = 0; m_out = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_len = int'(cfg_len); m_skip = int'(cfg_skip);
        m_dec = 0; m_in = 0; m_out = 0; m_ovf = 0;
        if (cfg_len == '0) nd = 1;
        else begin m_busy = 1; m_drain = 0; end
      end
    end else begin
      pop  = (sz > 0) && out_ready;
      keep = !m_drain && stream_valid && (m_dec == m_skip);
      fin  = m_drain && (m_ovf ? (sz == 0) : (pop && (m_out + 1 == m_len)));
      if (!m_drain && stream_valid) m_dec = keep ? 0 : m_dec + 1;
      if (pop) begin void'(mq.pop_front()); m_out++; end
      if (keep) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(pe_res);
        else m_ovf = 1;
        m_in++;
        if (m_in == m_len) m_drain = 1;
      end
      if (fin) begin m_busy = 0; m_drain = 0; nd = 1; end
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (dut_vec !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    got.delete(); done_cnt = 0;
    cfg_len = 4; cfg_skip = 0; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stream_valid = 1'b1; pe_res = (i + 1) * 32'h11;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== (i + 1) * 32'h11) begin
        bad++; $display("FAIL pass_latency[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, (i + 1) * 32'h11);
      end
    end
    stream_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL pass_cycle: got %h want %h", dut_vec, exp_vec()); end
      if (done) break;
    end
    tick();
    total++;
    if (got.size() != 4) begin bad++; $display("FAIL pass_count: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== (i + 1) * 32'h11) begin bad++; $display("FAIL pass_word[%0d]: got %h want %h", i, got[i], (i + 1) * 32'h11); end
    end
    total++;
    if (done_cnt != 1 || overflow !== 1'b0) begin
      bad++; $display("FAIL pass_done: got done_cnt=%0d ovf=%b want 1 0", done_cnt, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_decimation();
    got.delete(); done_cnt = 0;
    cfg_len = 2; cfg_skip = 3; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      stream_valid = 1'b1; pe_res = i;
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL dec_cycle: got %h want %h", dut_vec, exp_vec()); end
    end
    stream_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      tick();
      if (done) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL dec_busy_drop: got busy=%b want 0", busy); end
      end
    end
    tick();
    total++;
    if (got.size() != 2 || got[0] !== 32'd4 || got[1] !== 32'd8 || done_cnt != 1) begin
      bad++; $display("FAIL dec_words: got n=%0d done_cnt=%0d want words 4,8 done_cnt=1", got.size(), done_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    got.delete(); done_cnt = 0;
    cfg_len = 6; cfg_skip = 0; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      stream_valid = 1'b1; pe_res = i;
      tick();
      total++;
      if (out_data !== 32'd1 || dut_vec !== exp_vec()) begin
        bad++; $display("FAIL bp_hold: got d=%h vec=%h want d=1 vec=%h", out_data, dut_vec, exp_vec());
      end
    end
    stream_valid = 1'b0;
    tick();
    total++;
    if (fill !== FW'(4) || out_data !== 32'd1) begin
      bad++; $display("FAIL bp_full: got fill=%0d d=%h want 4 1", fill, out_data);
    end
    out_ready = 1'b1;
    for (int i = 5; i <= 6; i++) begin
      stream_valid = 1'b1; pe_res = i;
      tick();
      total++;
      if (fill !== FW'(4) || overflow !== 1'b0) begin
        bad++; $display("FAIL bp_pushpop: got fill=%0d ovf=%b want 4 0", fill, overflow);
      end
    end
    stream_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL bp_cycle: got %h want %h", dut_vec, exp_vec()); end
      if (done) break;
    end
    tick();
    total++;
    if (got.size() != 6 || done_cnt != 1) begin
      bad++; $display("FAIL bp_count: got n=%0d done_cnt=%0d want 6 1", got.size(), done_cnt);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      total++;
      if (got[i] !== i + 1) begin bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], i + 1); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    got.delete(); done_cnt = 0;
    cfg_len = 6; cfg_skip = 0; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      stream_valid = 1'b1; pe_res = i;
      tick();
    end
    stream_valid = 1'b0;
    total++;
    if (overflow !== 1'b1 || fill !== FW'(4) || busy !== 1'b1) begin
      bad++; $display("FAIL ovf_flag: got ovf=%b fill=%0d busy=%b want 1 4 1", overflow, fill, busy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ovf_cycle: got %h want %h", dut_vec, exp_vec()); end
      if (done) break;
    end
    tick();
    total++;
    if (got.size() != 4 || done_cnt != 1 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_drain: got n=%0d done_cnt=%0d ovf=%b want 4 1 1", got.size(), done_cnt, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    cfg_len = 0; cfg_skip = 0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL zero_done: got done=%b busy=%b ovf=%b want 1 0 0", done, busy, overflow);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored();
    got.delete(); done_cnt = 0;
    cfg_len = 3; cfg_skip = 0; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    stream_valid = 1'b1; pe_res = 32'hA;
    tick();
    start = 1'b1; cfg_len = 1; cfg_skip = 5; pe_res = 32'hB;
    tick();
    start = 1'b0; pe_res = 32'hC;
    tick();
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL start_ign_vec: got %h want %h", dut_vec, exp_vec()); end
    stream_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) break;
    end
    tick();
    total++;
    if (got.size() != 3 || done_cnt != 1) begin
      bad++; $display("FAIL start_ign: got n=%0d done_cnt=%0d want 3 1", got.size(), done_cnt);
    end else begin
      total++;
      if (got[2] !== 32'hC) begin bad++; $display("FAIL start_ign_last: got %h want c", got[2]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    got.delete(); done_cnt = 0;
    cfg_len = 5; cfg_skip = 0; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      stream_valid = 1'b1; pe_res = 32'h100 + i;
      tick();
    end
    stream_valid = 1'b0;
    total++;
    if (fill !== FW'(2)) begin bad++; $display("FAIL rst_mid_fill: got %0d want 2", fill); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (dut_vec !== '0 || done_cnt != 0) begin
      bad++; $display("FAIL rst_mid: got %h done_cnt=%0d want 0 0", dut_vec, done_cnt);
    end
    cfg_len = 2; cfg_skip = 1; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      stream_valid = 1'b1; pe_res = i;
      tick();
    end
    stream_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) break;
    end
    tick();
    total++;
    if (got.size() != 2 || got[0] !== 32'd2 || got[1] !== 32'd4 || done_cnt != 1) begin
      bad++; $display("FAIL rst_mid_next: got n=%0d done_cnt=%0d want words 2,4 done_cnt=1", got.size(), done_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int cyc;
    for (int j = 0; j < 12; j++) begin
      cfg_len = CNT_W'($urandom_range(1, 9));
      cfg_skip = 8'($urandom_range(0, 3));
      start = 1'b1;
      stream_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      pe_res = $urandom;
      tick();
      start = 1'b0;
      cyc = 0;
      while ((m_busy || m_done) && cyc < 500) begin
        stream_valid = ($urandom_range(0, 9) < 6);
        out_ready = ($urandom_range(0, 9) < 4);
        pe_res = $urandom;
        start = ($urandom_range(0, 15) == 0);
        cfg_len = CNT_W'($urandom_range(0, 9));
        tick();
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rand_cycle j=%0d c=%0d: got %h want %h", j, cyc, dut_vec, exp_vec()); end
        cyc++;
      end
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || cyc >= 500) begin bad++; $display("FAIL rand_timeout j=%0d: got busy=%b cyc=%0d want 0", j, busy, cyc); end
    end
    stream_valid = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_decimation();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_start_ignored();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pea_out_collector.md
Name: pea_out_collector

Overview:
- Output stage directly downstream of a PE in the PEA. Samples the PE result whenever the PE asserts its stream valid, optionally decimates (e.g. keeps only the final value of each accumulation window), and buffers results in a small FIFO.
- Drains the FIFO to the memory-side writer over a valid/ready handshake.
- Counts results per configured job and flags the end of the job.
- The PE has no backpressure, so the block flags overflow instead of stalling.

Parameters:
- N_BITS, 32, width of a PE result word.
- FIFO_DEPTH, 4, number of FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the job-length counters.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- start_i  in  1  single-cycle job start pulse.
- cfg_len_i  in  CNT_W  number of results to keep for the job.
- cfg_skip_i  in  8  keep 1 of every cfg_skip_i+1 valid results.
- pe_res_i  in  N_BITS  registered PE result.
- stream_valid_i  in  1  PE result valid.
- out_data_o  out  N_BITS  FIFO head word.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  consumer accepts the word.
- busy_o  out  1  job in progress.
- done_o  out  1  single-cycle pulse, job complete.
- overflow_o  out  1  sticky: a kept result was dropped because the FIFO was full.
- fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:

Reset:
- rst_n_i low at a clock edge returns the block to IDLE.
- Clears FIFO pointers and all counters.
- All outputs go to 0: out_data_o, out_valid_o, busy_o, done_o, overflow_o, fill_o.
- Reset mid-job discards buffered data with no done pulse.

FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - stream_valid_i and out_ready_i are ignored.
  - On start_i, latch cfg_len_i and cfg_skip_i; clear dec_cnt, in_cnt, out_cnt and overflow_o.
  - If latched len = 0: pulse done_o next cycle and stay in IDLE. Otherwise go to RUN.
- RUN:
  - On each stream_valid_i: if dec_cnt == skip, the result is "kept" and dec_cnt goes to 0; else dec_cnt+1.
  - A kept result is pushed to the FIFO and in_cnt increments.
  - When in_cnt reaches len, go to DRAIN on that same edge. Later stream_valid_i is ignored.
- DRAIN:
  - Capture is disabled.
  - When the last pop occurs (out_cnt reaches len), go to IDLE and pulse done_o for one cycle in the following cycle.
- busy_o = 1 in RUN and DRAIN.
- start_i is ignored in RUN and DRAIN.

FIFO / handshake:
- Pop occurs when out_valid_o && out_ready_i; out_cnt increments on each pop.
- out_valid_o = FIFO not empty.
- out_data_o = head entry, and must stay stable while out_valid_o && !out_ready_i.
- Latency: a push into an empty FIFO makes out_valid_o high in the next cycle.
- Push and pop in the same cycle are legal at any fill level, including full; fill is unchanged in that case.

Overflow:
- A kept result arriving when full with no pop that cycle is dropped and overflow_o is set (sticky until the next start_i or reset).
- in_cnt still increments for the dropped result, so the job terminates.
- If results were dropped, DRAIN ends when the FIFO is empty and no pop is in progress, instead of when out_cnt reaches len. done_o still pulses.

Counters:
- All counters are CNT_W bits, or 8 bits for dec_cnt.
- Comparisons use equality, so no wrap-around occurs within a job.
- cfg_skip_i = 0 keeps every valid result.

Test Plan:
- Basic pass-through: start with len=4, skip=0; 4 consecutive valids 0x11..0x44; out_ready_i=1 → outputs 0x11, 0x22, 0x33, 0x44 in order, each one cycle after capture. done_o pulses once, one cycle after the pop of 0x44. overflow_o=0.
- Decimation: len=2, skip=3; 8 valids with values 1..8 → only 4 and 8 are output. busy_o drops with done_o.
- Backpressure: FIFO_DEPTH=4, len=6, out_ready_i=0 while 4 valids arrive, then 1 → fill_o reaches 4. out_data_o holds the first word stable while stalled. The remaining 2 words push as slots free without loss once ready=1 (same-cycle push/pop when full). overflow_o=0.
- Overflow: len=6, out_ready_i=0 throughout the 6 valids, then 1 → 2 words dropped, overflow_o=1. Exactly 4 words are output. done_o pulses after the FIFO empties.
- Zero length and ignored start: start with len=0 → done_o pulses next cycle and busy_o stays 0. start_i asserted during RUN has no effect on the counters.
- Reset mid-job: reset asserted in RUN with fill=2 → next cycle all outputs are 0 and the state is IDLE. A subsequent job runs correctly.
